wb_trap_ctrl: RTL and testbench
===============================

WB_TRAP_CTRL -- requirements
Module: wb_trap_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning datapath and CSR width.
REQ-002 SHALL have parameter RF_AW, default 5, meaning register-id width.
REQ-003 SHALL have parameter NUM_EXT_IRQ, default 4, meaning number of external interrupt lines (legal 1..16).
REQ-004 SHALL have parameter FLUSH_CYCLES, default 3, meaning drain cycles after a redirect (legal 1..15).
REQ-005 SHALL have one clock and a synchronous, active-high reset: clk  in  1  clock; rst  in  1  reset.
REQ-006 SHALL have software_interrupt  in  1  machine software interrupt, level.
REQ-007 SHALL have timer_interrupt  in  1  machine timer interrupt, level.
REQ-008 SHALL have external_interrupt  in  NUM_EXT_IRQ  external lines, level.
REQ-009 SHALL have wb_valid  in  1  instruction present in WB.
REQ-010 SHALL have wb_pc  in  DATA_W  PC of the WB instruction.
REQ-011 SHALL have wb_reg_write, wb_reg_regid, wb_reg_writedata  in  1/RF_AW/DATA_W  register-file write request.
REQ-012 SHALL have wb_exception, wb_exc_code, wb_exc_tval  in  1/4/DATA_W  synchronous exception, cause, trap value.
REQ-013 SHALL have wb_mret  in  1  WB instruction is MRET.
REQ-014 SHALL have csr_write, csr_address, csr_writedata  in  1/12/DATA_W  resolved full-word CSR write.
REQ-015 SHALL have csr_readdata  out  DATA_W  combinational read of csr_address.
REQ-016 SHALL have rf_write, rf_regid, rf_writedata  out  1/RF_AW/DATA_W  register-file write port.
REQ-017 SHALL have redirect, redirect_pc  out  1/DATA_W  one-cycle fetch redirect.
REQ-018 SHALL have flush  out  1  squash younger pipeline stages.
REQ-019 SHALL have irq_claim_id  out  4  index of the last external line taken.

Function
REQ-020 SHALL implement CSRs: mstatus 0x300 (MIE[3], MPIE[7], MPP[12:11] reads 2'b11); mie 0x304 (MSIE[3], MTIE[7], MEIE[11]); mtvec 0x305 (base[DATA_W-1:2], mode[1:0], mode values 2–3 treated as 0); mscratch 0x340; mepc 0x341 (bits[1:0] read 0); mcause 0x342; mtval 0x343; mip 0x344 read-only (MSIP[3], MTIP[7], MEIP[11]); unmapped addresses read 0 and ignore writes.
REQ-021 SHALL use FSM states RUN, REDIRECT and DRAIN; RUN->REDIRECT on trap or mret; REDIRECT->DRAIN after one cycle; DRAIN->RUN after FLUSH_CYCLES cycles, counted by a down-counter.
REQ-022 SHALL treat a cycle as a commit candidate only when state==RUN && wb_valid; wb_valid SHALL be ignored in REDIRECT and DRAIN.
REQ-023 SHALL take traps in this priority on a candidate: exception > MEI > MSI > MTI. An interrupt is taken only if mstatus.MIE and the matching mie bit are 1. MEIP = OR of external_interrupt.
REQ-024 SHALL on a trap: suppress rf_write and csr_write; mepc<=wb_pc; mcause<={interrupt bit at DATA_W-1, zero-extended code} with code = wb_exc_code, 11, 3 or 7; mtval<=wb_exc_tval for an exception, else 0; MPIE<=MIE; MIE<=0.
REQ-025 SHALL, when an external interrupt is taken, set irq_claim_id to the lowest asserted external line index.
REQ-026 SHALL on mret without a trap: MIE<=MPIE, MPIE<=1, redirect_pc=mepc, rf_write suppressed. A trap on the same instruction SHALL win over mret.
REQ-027 SHALL register redirect and redirect_pc: in the cycle after detection, redirect=1 for exactly one cycle. For a trap, redirect_pc = {base,2'b00}, or {base,2'b00}+4*code for an interrupt when mode==1; arithmetic is modulo 2^DATA_W.
REQ-028 SHALL assert flush throughout REDIRECT and DRAIN, and deassert it in RUN.
REQ-029 SHALL set rf_write = candidate && wb_reg_write && wb_reg_regid!=0 && no trap && !wb_mret; rf_regid and rf_writedata pass through combinationally.
REQ-030 SHALL commit csr_write only on a non-trapping candidate; the write is visible on csr_readdata the following cycle.

Reset
REQ-031 SHALL on rst (including mid-DRAIN): state RUN, counter 0; all CSRs 0 except MPP; rf_write, redirect, flush 0; redirect_pc 0; irq_claim_id 0.

Verification
REQ-032 Write mtvec=0x100 then issue an exception with code 2, wb_pc=0x40, tval=0xDEAD -> next cycle redirect=1, redirect_pc=0x100; mepc=0x40, mcause=2, mtval=0xDEAD, rf_write=0; flush for 1+3 cycles.
REQ-033 Set mtvec=0x101, MIE=1, MEIE=1, external_interrupt=4'b0110, wb_valid=1 -> redirect_pc=0x12C, mcause=0x8000000B, irq_claim_id=1.
REQ-034 Hold MSIP and MTIP together with MSIE=MTIE=MIE=1 -> mcause=0x80000003; MIE=0 and MPIE=1 afterwards.
REQ-035 Issue mret with mepc=0x200 and MPIE=1 -> redirect_pc=0x200, MIE=1; wb_valid with rf write requests during DRAIN -> rf_write stays 0.
REQ-036 Assert rst during DRAIN -> next cycle flush=0 and state is RUN; a retire to x5 writes; a retire to x0 does not.

Source files
------------

// File: rtl/wb_trap_if.sv
// Bus bundle for wb_trap_ctrl: write-back commit, CSR access, interrupt lines
// and the redirect/flush/register-file outputs.
interface wb_trap_if #(
  parameter int DATA_W      = 32,
  parameter int RF_AW       = 5,
  parameter int NUM_EXT_IRQ = 4
);
  logic                   software_interrupt;
  logic                   timer_interrupt;
  logic [NUM_EXT_IRQ-1:0] external_interrupt;
  logic                   wb_valid;
  logic [DATA_W-1:0]      wb_pc;
  logic                   wb_reg_write;
  logic [RF_AW-1:0]       wb_reg_regid;
  logic [DATA_W-1:0]      wb_reg_writedata;
  logic                   wb_exception;
  logic [3:0]             wb_exc_code;
  logic [DATA_W-1:0]      wb_exc_tval;
  logic                   wb_mret;
  logic                   csr_write;
  logic [11:0]            csr_address;
  logic [DATA_W-1:0]      csr_writedata;
  logic [DATA_W-1:0]      csr_readdata;
  logic                   rf_write;
  logic [RF_AW-1:0]       rf_regid;
  logic [DATA_W-1:0]      rf_writedata;
  logic                   redirect;
  logic [DATA_W-1:0]      redirect_pc;
  logic                   flush;
  logic [3:0]             irq_claim_id;

  modport slave (
    input  software_interrupt, timer_interrupt, external_interrupt,
    input  wb_valid, wb_pc, wb_reg_write, wb_reg_regid, wb_reg_writedata,
    input  wb_exception, wb_exc_code, wb_exc_tval, wb_mret,
    input  csr_write, csr_address, csr_writedata,
    output csr_readdata, rf_write, rf_regid, rf_writedata,
    output redirect, redirect_pc, flush, irq_claim_id
  );

  modport master (
    output software_interrupt, timer_interrupt, external_interrupt,
    output wb_valid, wb_pc, wb_reg_write, wb_reg_regid, wb_reg_writedata,
    output wb_exception, wb_exc_code, wb_exc_tval, wb_mret,
    output csr_write, csr_address, csr_writedata,
    input  csr_readdata, rf_write, rf_regid, rf_writedata,
    input  redirect, redirect_pc, flush, irq_claim_id
  );
endinterface

// File: rtl/wb_trap_ctrl.sv
// Machine-mode trap controller at write-back: CSR file, trap/mret arbitration,
// registered fetch redirect and a fixed-length pipeline drain.
module wb_trap_ctrl #(
  parameter int DATA_W       = 32,
  parameter int RF_AW        = 5,
  parameter int NUM_EXT_IRQ  = 4,
  parameter int FLUSH_CYCLES = 3
) (
  input logic     clk,
  input logic     rst,
  wb_trap_if.slave bus
);
  typedef enum logic [1:0] {RUN, REDIRECT, DRAIN} state_t;

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MTVAL    = 12'h343;
  localparam logic [11:0] A_MIP      = 12'h344;

  state_t            r_state, w_state_nxt;
  logic [3:0]        r_cnt, w_cnt_nxt;
  logic              r_mstatus_mie, r_mstatus_mpie;
  logic              r_msie, r_mtie, r_meie;
  logic [DATA_W-1:0] r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;
  logic              r_redirect;
  logic [DATA_W-1:0] r_redirect_pc;
  logic [3:0]        r_claim;

  logic              w_cand, w_meip, w_trap, w_intr, w_mret_go, w_csr_we;
  logic [3:0]        w_code, w_claim;
  logic [DATA_W-1:0] w_base, w_target, w_cause, w_mstatus, w_mie, w_mip;

  assign w_cand    = (r_state == RUN) && bus.wb_valid;
  assign w_meip    = |bus.external_interrupt;
  assign w_mret_go = w_cand && bus.wb_mret && !w_trap;
  assign w_csr_we  = w_cand && !w_trap && bus.csr_write;
  assign w_cause   = {w_intr, {(DATA_W-5){1'b0}}, w_code};
  assign w_base    = {r_mtvec[DATA_W-1:2], 2'b00};

  // Exception outranks every interrupt; among interrupts MEI > MSI > MTI.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_trap = 1'b0;
    w_intr = 1'b0;
    w_code = 4'd0;
    if (w_cand) begin
      if (bus.wb_exception) begin
        w_trap = 1'b1;
        w_code = bus.wb_exc_code;
      end else if (r_mstatus_mie && r_meie && w_meip) begin
        w_trap = 1'b1; w_intr = 1'b1; w_code = 4'd11;
      end else if (r_mstatus_mie && r_msie && bus.software_interrupt) begin
        w_trap = 1'b1; w_intr = 1'b1; w_code = 4'd3;
      end else if (r_mstatus_mie && r_mtie && bus.timer_interrupt) begin
        w_trap = 1'b1; w_intr = 1'b1; w_code = 4'd7;
      end
    end
  end

  always_comb begin
    w_claim = 4'd0;
    for (int i = NUM_EXT_IRQ - 1; i >= 0; i--)
      if (bus.external_interrupt[i]) w_claim = 4'(i);
  end

  // Vectored mode only applies to interrupts; modes 2 and 3 behave as direct.
  always_comb begin
    w_target = r_mepc;
    if (w_trap) begin
      w_target = w_base;
      if (w_intr && r_mtvec[1:0] == 2'b01)
        w_target = w_base + {{(DATA_W-6){1'b0}}, w_code, 2'b00};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      RUN:      if (w_trap || w_mret_go) w_state_nxt = REDIRECT;
      REDIRECT: begin
        w_state_nxt = DRAIN;
        w_cnt_nxt   = 4'(FLUSH_CYCLES - 1);
      end
      DRAIN:    if (r_cnt == 4'd0) w_state_nxt = RUN;
                else w_cnt_nxt = r_cnt - 4'd1;
      default:  w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      r_state <= RUN;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Later assignments win: mret overrides a same-cycle mstatus write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_msie         <= 1'b0;
      r_mtie         <= 1'b0;
      r_meie         <= 1'b0;
      r_mtvec        <= '0;
      r_mscratch     <= '0;
      r_mepc         <= '0;
      r_mcause       <= '0;
      r_mtval        <= '0;
      r_redirect     <= 1'b0;
      r_redirect_pc  <= '0;
      r_claim        <= 4'd0;
    end else begin
      if (w_csr_we) begin
        case (bus.csr_address)
          A_MSTATUS: begin
            r_mstatus_mie  <= bus.csr_writedata[3];
            r_mstatus_mpie <= bus.csr_writedata[7];
          end
          A_MIE: begin
            r_msie <= bus.csr_writedata[3];
            r_mtie <= bus.csr_writedata[7];
            r_meie <= bus.csr_writedata[11];
          end
          A_MTVEC:    r_mtvec    <= bus.csr_writedata;
          A_MSCRATCH: r_mscratch <= bus.csr_writedata;
          A_MEPC:     r_mepc     <= {bus.csr_writedata[DATA_W-1:2], 2'b00};
          A_MCAUSE:   r_mcause   <= bus.csr_writedata;
          A_MTVAL:    r_mtval    <= bus.csr_writedata;
          default: ;
        endcase
      end
      if (w_mret_go) begin
        r_mstatus_mie  <= r_mstatus_mpie;
        r_mstatus_mpie <= 1'b1;
      end
      if (w_trap) begin
        r_mepc         <= {bus.wb_pc[DATA_W-1:2], 2'b00};
        r_mcause       <= w_cause;
        r_mtval        <= w_intr ? '0 : bus.wb_exc_tval;
        r_mstatus_mpie <= r_mstatus_mie;
        r_mstatus_mie  <= 1'b0;
        if (w_intr && w_code == 4'd11) r_claim <= w_claim;
      end
      r_redirect <= w_trap || w_mret_go;
      if (w_trap || w_mret_go) r_redirect_pc <= w_target;
    end
  end

  always_comb begin
    w_mstatus        = '0;
    w_mstatus[3]     = r_mstatus_mie;
    w_mstatus[7]     = r_mstatus_mpie;
    w_mstatus[12:11] = 2'b11;
    w_mie            = '0;
    w_mie[3]         = r_msie;
    w_mie[7]         = r_mtie;
    w_mie[11]        = r_meie;
    w_mip            = '0;
    w_mip[3]         = bus.software_interrupt;
    w_mip[7]         = bus.timer_interrupt;
    w_mip[11]        = w_meip;
  end

  always_comb begin
    case (bus.csr_address)
      A_MSTATUS:  bus.csr_readdata = w_mstatus;
      A_MIE:      bus.csr_readdata = w_mie;
      A_MTVEC:    bus.csr_readdata = r_mtvec;
      A_MSCRATCH: bus.csr_readdata = r_mscratch;
      A_MEPC:     bus.csr_readdata = r_mepc;
      A_MCAUSE:   bus.csr_readdata = r_mcause;
      A_MTVAL:    bus.csr_readdata = r_mtval;
      A_MIP:      bus.csr_readdata = w_mip;
      default:    bus.csr_readdata = '0;
    endcase
  end

  assign bus.rf_write     = w_cand && bus.wb_reg_write && (bus.wb_reg_regid != '0)
                            && !w_trap && !bus.wb_mret;
  assign bus.rf_regid     = bus.wb_reg_regid;
  assign bus.rf_writedata = bus.wb_reg_writedata;
  assign bus.redirect     = r_redirect;
  assign bus.redirect_pc  = r_redirect_pc;
  assign bus.flush        = (r_state != RUN);
  assign bus.irq_claim_id = r_claim;
endmodule

// File: tb/tb_wb_trap_ctrl.sv
// Self-checking bench for wb_trap_ctrl: reference model of the trap rules,
// a table of single-commit vectors, scripted corner cases and random traffic.
module tb_wb_trap_ctrl;
  localparam int DW = 32;
  localparam int FC = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_trap_if #(.DATA_W(DW), .RF_AW(5), .NUM_EXT_IRQ(4)) bus ();

  wb_trap_ctrl #(.DATA_W(DW), .RF_AW(5), .NUM_EXT_IRQ(4), .FLUSH_CYCLES(FC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic        rst;
    logic        sw;
    logic        tm;
    logic [3:0]  ext;
    logic        valid;
    logic [31:0] pc;
    logic        rw;
    logic [4:0]  rid;
    logic [31:0] rwd;
    logic        exc;
    logic [3:0]  code;
    logic [31:0] tval;
    logic        mret;
    logic        cw;
    logic [11:0] ca;
    logic [31:0] cwd;
  } stim_t;

  typedef struct packed {
    logic        rf_write;
    logic [4:0]  rf_regid;
    logic [31:0] rf_wd;
    logic        flush;
    logic        redirect;
    logic [31:0] rpc;
    logic [3:0]  claim;
    logic [31:0] rd;
  } obs_t;

  typedef struct {
    stim_t       in;
    logic        exp_rf;
    logic        exp_red;
    logic [31:0] exp_pc;
    logic [31:0] exp_cause;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;
  bit model_on = 1'b0;

  // Reference state: flush is modelled as a count of squash cycles still owed.
  int          m_left;
  bit          m_red;
  logic [31:0] m_rpc;
  logic [3:0]  m_claim;
  bit          m_mie, m_mpie, m_msie, m_mtie, m_meie;
  logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  task automatic m_reset();
    m_left = 0; m_red = 0; m_rpc = '0; m_claim = '0;
    m_mie = 0; m_mpie = 0; m_msie = 0; m_mtie = 0; m_meie = 0;
    m_mtvec = '0; m_mscratch = '0; m_mepc = '0; m_mcause = '0; m_mtval = '0;
  endtask

  function automatic logic [31:0] m_read(input logic [11:0] a, input stim_t s);
    case (a)
      12'h300: return 32'h1800 | (32'(m_mie) << 3) | (32'(m_mpie) << 7);
      12'h304: return (32'(m_msie) << 3) | (32'(m_mtie) << 7) | (32'(m_meie) << 11);
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc & ~32'h3;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'h344: return (32'(s.sw) << 3) | (32'(s.tm) << 7) | (32'(|s.ext) << 11);
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step(input stim_t s, input obs_t o);
    bit cand, trap, intr, mret_go, exp_rf, found;
    logic [3:0]  code;
    logic [31:0] base, tgt;
    cand = s.valid && (m_left == 0);
    trap = 0; intr = 0; code = 4'd0;
    if (cand) begin
      if (s.exc) begin trap = 1; code = s.code; end
      else if (m_mie && m_meie && |s.ext) begin trap = 1; intr = 1; code = 4'd11; end
      else if (m_mie && m_msie && s.sw)   begin trap = 1; intr = 1; code = 4'd3;  end
      else if (m_mie && m_mtie && s.tm)   begin trap = 1; intr = 1; code = 4'd7;  end
    end
    mret_go = cand && s.mret && !trap;
    exp_rf  = cand && s.rw && (s.rid != 5'd0) && !trap && !s.mret;

    check("rf_write", 64'(o.rf_write), 64'(exp_rf));
    check("rf_regid", 64'(o.rf_regid), 64'(s.rid));
    check("rf_writedata", 64'(o.rf_wd), 64'(s.rwd));
    check("flush", 64'(o.flush), 64'(m_left > 0));
    check("redirect", 64'(o.redirect), 64'(m_red));
    check("redirect_pc", 64'(o.rpc), 64'(m_rpc));
    check("irq_claim_id", 64'(o.claim), 64'(m_claim));
    check("csr_readdata", 64'(o.rd), 64'(m_read(s.ca, s)));

    if (s.rst) m_reset();
    else begin
      base = m_mtvec & ~32'h3;
      if (trap) tgt = (intr && m_mtvec[1:0] == 2'b01) ? base + 32'(code) * 32'd4 : base;
      else      tgt = m_mepc & ~32'h3;
      m_red = trap || mret_go;
      if (m_red) m_rpc = tgt;
      m_left = m_red ? FC + 1 : (m_left > 0 ? m_left - 1 : 0);
      if (cand && !trap && s.cw) begin
        case (s.ca)
          12'h300: begin m_mie = s.cwd[3]; m_mpie = s.cwd[7]; end
          12'h304: begin m_msie = s.cwd[3]; m_mtie = s.cwd[7]; m_meie = s.cwd[11]; end
          12'h305: m_mtvec    = s.cwd;
          12'h340: m_mscratch = s.cwd;
          12'h341: m_mepc     = s.cwd;
          12'h342: m_mcause   = s.cwd;
          12'h343: m_mtval    = s.cwd;
          default: ;
        endcase
      end
      if (mret_go) begin m_mie = m_mpie; m_mpie = 1; end
      if (trap) begin
        m_mepc   = s.pc;
        m_mcause = {intr, 27'd0, code};
        m_mtval  = intr ? 32'h0 : s.tval;
        m_mpie   = m_mie;
        m_mie    = 0;
        if (intr && code == 4'd11) begin
          found = 0;
          for (int i = 0; i < 4; i++)
            if (s.ext[i] && !found) begin m_claim = 4'(i); found = 1; end
        end
      end
    end
  endtask

  task automatic drive_cycle(input stim_t s, output obs_t o);
    rst                    = s.rst;
    bus.software_interrupt = s.sw;
    bus.timer_interrupt    = s.tm;
    bus.external_interrupt = s.ext;
    bus.wb_valid           = s.valid;
    bus.wb_pc              = s.pc;
    bus.wb_reg_write       = s.rw;
    bus.wb_reg_regid       = s.rid;
    bus.wb_reg_writedata   = s.rwd;
    bus.wb_exception       = s.exc;
    bus.wb_exc_code        = s.code;
    bus.wb_exc_tval        = s.tval;
    bus.wb_mret            = s.mret;
    bus.csr_write          = s.cw;
    bus.csr_address        = s.ca;
    bus.csr_writedata      = s.cwd;
    @(negedge clk);
    o.rf_write = bus.rf_write;
    o.rf_regid = bus.rf_regid;
    o.rf_wd    = bus.rf_writedata;
    o.flush    = bus.flush;
    o.redirect = bus.redirect;
    o.rpc      = bus.redirect_pc;
    o.claim    = bus.irq_claim_id;
    o.rd       = bus.csr_readdata;
    if (model_on) model_step(s, o);
    @(posedge clk);
    #1;
  endtask

  function automatic stim_t idle(input logic [11:0] rd_addr);
    stim_t s;
    s    = '0;
    s.ca = rd_addr;
    return s;
  endfunction

  function automatic stim_t csrw(input logic [11:0] a, input logic [31:0] d);
    stim_t s;
    s     = '0;
    s.valid = 1'b1;
    s.cw  = 1'b1;
    s.ca  = a;
    s.cwd = d;
    return s;
  endfunction

  function automatic stim_t mk(input logic v, input logic e, input logic [3:0] c,
                               input logic mr, input logic sw, input logic tm,
                               input logic [3:0] ext, input logic rw, input logic [4:0] rid);
    stim_t s;
    s = '0;
    s.valid = v; s.exc = e; s.code = c; s.mret = mr; s.sw = sw; s.tm = tm;
    s.ext = ext; s.rw = rw; s.rid = rid;
    s.pc = 32'h80; s.tval = 32'h55; s.rwd = 32'hABCD;
    return s;
  endfunction

  task automatic do_reset();
    stim_t s;
    obs_t  o;
    s = idle(12'h0);
    s.rst = 1'b1;
    drive_cycle(s, o);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  initial begin
    vec_t  vecs[9];
    stim_t s;
    obs_t  o;
    int    nflush;

    vecs[0] = '{mk(1,0,4'd0,0,0,0,4'b0000,1,5'd5), 1'b1, 1'b0, 32'h0,   32'h0};
    vecs[1] = '{mk(1,0,4'd0,0,0,0,4'b0000,1,5'd0), 1'b0, 1'b0, 32'h0,   32'h0};
    vecs[2] = '{mk(1,1,4'd5,0,0,0,4'b0000,1,5'd5), 1'b0, 1'b1, 32'h100, 32'h5};
    vecs[3] = '{mk(1,0,4'd0,0,0,0,4'b1000,1,5'd5), 1'b0, 1'b1, 32'h12C, 32'h8000000B};
    vecs[4] = '{mk(1,0,4'd0,0,1,1,4'b0000,0,5'd0), 1'b0, 1'b1, 32'h10C, 32'h80000003};
    vecs[5] = '{mk(1,0,4'd0,0,0,1,4'b0000,0,5'd0), 1'b0, 1'b1, 32'h11C, 32'h80000007};
    vecs[6] = '{mk(1,1,4'd1,1,0,0,4'b0001,0,5'd0), 1'b0, 1'b1, 32'h100, 32'h1};
    vecs[7] = '{mk(1,0,4'd0,1,0,0,4'b0000,1,5'd6), 1'b0, 1'b1, 32'h80,  32'h1};
    vecs[8] = '{mk(0,0,4'd0,0,0,0,4'b0010,1,5'd5), 1'b0, 1'b0, 32'h0,   32'h0};

    m_reset();
    do_reset();
    do_reset();
    model_on = 1'b1;

    // Reset state, read back through the CSR port.
    drive_cycle(idle(12'h300), o);
    check("reset_mstatus", 64'(o.rd), 64'h1800);
    check("reset_flush", 64'(o.flush), 64'h0);
    check("reset_redirect_pc", 64'(o.rpc), 64'h0);
    drive_cycle(idle(12'h305), o);
    check("reset_mtvec", 64'(o.rd), 64'h0);

    // Table-driven single commits from a fixed CSR configuration.
    for (int i = 0; i < 9; i++) begin
      drive_cycle(csrw(12'h305, 32'h101), o);
      drive_cycle(csrw(12'h300, 32'h8), o);
      drive_cycle(csrw(12'h304, 32'h888), o);
      drive_cycle(vecs[i].in, o);
      check($sformatf("vec%0d_rf_write", i), 64'(o.rf_write), 64'(vecs[i].exp_rf));
      drive_cycle(idle(12'h342), o);
      check($sformatf("vec%0d_redirect", i), 64'(o.redirect), 64'(vecs[i].exp_red));
      check($sformatf("vec%0d_flush", i), 64'(o.flush), 64'(vecs[i].exp_red));
      if (vecs[i].exp_red) begin
        check($sformatf("vec%0d_redirect_pc", i), 64'(o.rpc), 64'(vecs[i].exp_pc));
        check($sformatf("vec%0d_mcause", i), 64'(o.rd), 64'(vecs[i].exp_cause));
      end
      for (int k = 0; k < 4; k++) drive_cycle(idle(12'h0), o);
    end

    // Exception into direct-mode vector, then the full squash window.
    do_reset();
    drive_cycle(csrw(12'h305, 32'h100), o);
    s = mk(1,1,4'd2,0,0,0,4'b0000,1,5'd3);
    s.pc = 32'h40; s.tval = 32'hDEAD;
    drive_cycle(s, o);
    check("exc_rf_write", 64'(o.rf_write), 64'h0);
    nflush = 0;
    drive_cycle(idle(12'h341), o);
    check("exc_redirect", 64'(o.redirect), 64'h1);
    check("exc_redirect_pc", 64'(o.rpc), 64'h100);
    check("exc_mepc", 64'(o.rd), 64'h40);
    nflush += int'(o.flush);
    drive_cycle(idle(12'h342), o);
    check("exc_redirect_once", 64'(o.redirect), 64'h0);
    check("exc_mcause", 64'(o.rd), 64'h2);
    nflush += int'(o.flush);
    drive_cycle(idle(12'h343), o);
    check("exc_mtval", 64'(o.rd), 64'hDEAD);
    nflush += int'(o.flush);
    for (int k = 0; k < 3; k++) begin
      drive_cycle(idle(12'h0), o);
      nflush += int'(o.flush);
    end
    check("exc_flush_cycles", 64'(nflush), 64'(1 + FC));

    // Vectored external interrupt, lowest pending line claimed.
    do_reset();
    drive_cycle(csrw(12'h305, 32'h101), o);
    drive_cycle(csrw(12'h300, 32'h8), o);
    drive_cycle(csrw(12'h304, 32'h800), o);
    drive_cycle(mk(1,0,4'd0,0,0,0,4'b0110,0,5'd0), o);
    drive_cycle(idle(12'h342), o);
    check("mei_redirect_pc", 64'(o.rpc), 64'h12C);
    check("mei_mcause", 64'(o.rd), 64'h8000000B);
    check("mei_claim", 64'(o.claim), 64'h1);

    // Software beats timer; MIE stacks into MPIE.
    do_reset();
    drive_cycle(csrw(12'h305, 32'h100), o);
    drive_cycle(csrw(12'h300, 32'h8), o);
    drive_cycle(csrw(12'h304, 32'h88), o);
    drive_cycle(mk(1,0,4'd0,0,1,1,4'b0000,0,5'd0), o);
    drive_cycle(idle(12'h342), o);
    check("msi_mcause", 64'(o.rd), 64'h80000003);
    drive_cycle(idle(12'h300), o);
    check("msi_mstatus", 64'(o.rd), 64'h1880);

    // mret restores MIE; retires during the drain must not write.
    do_reset();
    drive_cycle(csrw(12'h341, 32'h200), o);
    drive_cycle(csrw(12'h300, 32'h80), o);
    drive_cycle(mk(1,0,4'd0,1,0,0,4'b0000,1,5'd7), o);
    check("mret_rf_write", 64'(o.rf_write), 64'h0);
    drive_cycle(idle(12'h300), o);
    check("mret_redirect_pc", 64'(o.rpc), 64'h200);
    check("mret_mstatus", 64'(o.rd), 64'h1888);
    for (int k = 0; k < FC; k++) begin
      drive_cycle(mk(1,0,4'd0,0,0,0,4'b0000,1,5'd9), o);
      check("drain_rf_write", 64'(o.rf_write), 64'h0);
    end
    drive_cycle(mk(1,0,4'd0,0,0,0,4'b0000,1,5'd9), o);
    check("after_drain_rf_write", 64'(o.rf_write), 64'h1);

    // Reset in the middle of a drain.
    do_reset();
    drive_cycle(mk(1,1,4'd4,0,0,0,4'b0000,0,5'd0), o);
    drive_cycle(idle(12'h0), o);
    s = idle(12'h0);
    s.rst = 1'b1;
    drive_cycle(s, o);
    check("rst_drain_flush_before", 64'(o.flush), 64'h1);
    s = mk(1,0,4'd0,0,0,0,4'b0000,1,5'd5);
    s.ca = 12'h300;
    drive_cycle(s, o);
    check("rst_drain_flush", 64'(o.flush), 64'h0);
    check("rst_drain_rf_x5", 64'(o.rf_write), 64'h1);
    check("rst_drain_mstatus", 64'(o.rd), 64'h1800);
    check("rst_drain_redirect_pc", 64'(o.rpc), 64'h0);
    drive_cycle(mk(1,0,4'd0,0,0,0,4'b0000,1,5'd0), o);
    check("rst_drain_rf_x0", 64'(o.rf_write), 64'h0);

    // Random traffic against the reference model.
    for (int n = 0; n < 2000; n++) begin
      logic [11:0] addrs[9];
      addrs = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344, 12'h7C0};
      s = '0;
      s.rst   = ($urandom_range(0, 199) == 0);
      s.sw    = ($urandom_range(0, 3) == 0);
      s.tm    = ($urandom_range(0, 3) == 0);
      for (int b = 0; b < 4; b++) s.ext[b] = ($urandom_range(0, 7) == 0);
      s.valid = ($urandom_range(0, 3) != 0);
      s.pc    = $urandom;
      s.rw    = $urandom_range(0, 1);
      s.rid   = 5'($urandom_range(0, 31));
      s.rwd   = $urandom;
      s.exc   = ($urandom_range(0, 15) == 0);
      s.code  = 4'($urandom_range(0, 15));
      s.tval  = $urandom;
      s.mret  = ($urandom_range(0, 15) == 0);
      s.cw    = !s.mret && ($urandom_range(0, 2) == 0);
      s.ca    = addrs[$urandom_range(0, 8)];
      s.cwd   = $urandom;
      drive_cycle(s, o);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
